// File: rtl/celebration_led_scheduler.sv
// celebration_led_scheduler: shares the tri-colour status LED between prioritised match-event
// blink sequences and the end-of-game rainbow generator.  Rev 1.0
`default_nettype none

module celebration_led_scheduler #(
  parameter int BLINK_HALF = 12_500_000,
  parameter int BLINKS     = 3,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_wicket,
  input  logic       ev_six,
  input  logic       ev_four,
  input  logic       game_over,
  input  logic       rb_red,
  input  logic       rb_grn,
  input  logic       rb_blu,
  output logic       rainbow_en,
  output logic       red,
  output logic       grn,
  output logic       blu,
  output logic       busy,
  output logic [1:0] cur_event
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHOW    = 2'd1,
    S_GAP     = 2'd2,
    S_RAINBOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_ph_last = CNT_W'(BLINK_HALF - 1);
  localparam logic [3:0]       c_bl_last = 4'(BLINKS);

  state_t           state_q, state_d;
  logic [2:0]       pend_q, pend_d;   // {wicket, six, four}
  logic [2:0]       col_q, col_d;     // {red, grn, blu}
  logic [2:0]       led_q, led_d;
  logic [1:0]       ev_q, ev_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       blink_q, blink_d;
  logic [2:0]       clr;
  logic             drop_all;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      col_q   <= '0;
      led_q   <= '0;
      ev_q    <= '0;
      phase_q <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      col_q   <= col_d;
      led_q   <= led_d;
      ev_q    <= ev_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    ev_d     = ev_q;
    phase_d  = phase_q;
    blink_d  = blink_q;
    clr      = 3'b000;
    drop_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (game_over) begin
          state_d  = S_RAINBOW;
          drop_all = 1'b1;
        end else if (pend_q != 3'b000) begin
          state_d = S_SHOW;
          phase_d = '0;
          blink_d = 4'd1;
          if (pend_q[2]) begin
            clr   = 3'b100;
            col_d = 3'b100;
            ev_d  = 2'd3;
          end else if (pend_q[1]) begin
            clr   = 3'b010;
            col_d = 3'b010;
            ev_d  = 2'd2;
          end else begin
            clr   = 3'b001;
            col_d = 3'b001;
            ev_d  = 2'd1;
          end
        end
      end

      S_SHOW, S_GAP: begin
        if (game_over) begin
          state_d  = S_RAINBOW;
          drop_all = 1'b1;
          ev_d     = 2'd0;
          phase_d  = '0;
          blink_d  = '0;
        end else if (phase_q == c_ph_last) begin
          phase_d = '0;
          if (state_q == S_SHOW) begin
            state_d = S_GAP;
          end else if (blink_q == c_bl_last) begin
            state_d = S_IDLE;
            ev_d    = 2'd0;
          end else begin
            blink_d = blink_q + 4'd1;
            state_d = S_SHOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_RAINBOW: begin
        drop_all = 1'b1;
        if (!game_over) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A grant clears its bit but a same-cycle pulse re-arms it, so the shown event can replay once.
  always_comb begin
    if (drop_all) begin
      pend_d = 3'b000;
    end else begin
      pend_d = (pend_q & ~clr) | {ev_wicket, ev_six, ev_four};
    end
  end

  always_comb begin
    case (state_d)
      S_SHOW:    led_d = col_d;
      S_RAINBOW: led_d = {rb_red, rb_grn, rb_blu};
      default:   led_d = 3'b000;
    endcase
  end

  assign red        = led_q[2];
  assign grn        = led_q[1];
  assign blu        = led_q[0];
  assign busy       = (state_q != S_IDLE);
  assign rainbow_en = (state_q == S_RAINBOW);
  assign cur_event  = ev_q;

endmodule

`default_nettype wire

// File: doc/celebration_led_scheduler.md
Name: celebration_led_scheduler

Overview:
- Owns the single tri-colour status LED and shares it between match-event flashes (wicket, six, four) and the end-of-game rainbow generator.
- Latches single-cycle event pulses from the scoring logic and arbitrates them by fixed priority.
- Plays each granted event as a timed blink sequence.
- When game_over is high, hands the LED to the rainbow generator by driving its enable and passing its colour outputs through.

Parameters:
- BLINK_HALF, 12_500_000, clk cycles per on-phase and per off-phase (0.25 s at 50 MHz); legal range 1..2^CNT_W-1.
- BLINKS, 3, on-phases per event sequence; legal range 1..15.
- CNT_W, 24, width of the phase counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ev_wicket  in  1  single-cycle pulse: wicket fell.
- ev_six  in  1  single-cycle pulse: six scored.
- ev_four  in  1  single-cycle pulse: four scored.
- game_over  in  1  level: match finished.
- rb_red, rb_grn, rb_blu  in  1 each  colour outputs of the rainbow generator.
- rainbow_en  out  1  drives the rainbow generator's game_over input.
- red, grn, blu  out  1 each  LED drive, registered.
- busy  out  1  high in any state other than IDLE.
- cur_event  out  2  event being shown: 0 none, 1 four, 2 six, 3 wicket.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; pending bits, phase counter and blink counter clear.
  - red, grn, blu, rainbow_en and busy are 0; cur_event is 0.
- Pending register:
  - There are 3 bits: wicket, six, four.
  - A pulse sampled at edge N sets its bit at edge N.
  - Repeat pulses of an event that is already pending coalesce into one bit.
  - A pulse of the event currently being shown sets its bit again, so that event replays once.
  - If a set and a clear of the same bit land in the same cycle, the set wins.
- States: IDLE, SHOW, GAP, RAINBOW.
  - IDLE:
    - If game_over: go to RAINBOW.
    - Else if any pending bit is set: grant by priority wicket > six > four. In the same edge, clear the granted bit, latch the colour (wicket=red, six=grn, four=blu), set cur_event, load the phase counter to 0 and the blink counter to 1, and go to SHOW.
    - Else stay in IDLE with all LEDs 0.
  - SHOW:
    - The latched colour bit is 1 and the others are 0.
    - The phase counter increments each cycle. When it reaches BLINK_HALF-1, it resets to 0 and the state goes to GAP.
  - GAP:
    - All LEDs are 0.
    - At phase counter BLINK_HALF-1, reset the counter. If blink counter == BLINKS, go to IDLE and clear cur_event to 0. Otherwise increment the blink counter and go to SHOW.
  - RAINBOW:
    - rainbow_en is 1.
    - red/grn/blu are rb_red/rb_grn/rb_blu registered, i.e. one clk delay.
    - All pending bits are held clear; event pulses are ignored.
    - When game_over falls, go to IDLE with LEDs 0 and rainbow_en 0.
- game_over priority: if game_over is sampled high in SHOW or GAP, the sequence aborts at that edge and the state goes to RAINBOW. Pending bits and cur_event clear.
- Timing:
  - Minimum latency from event pulse to LED on is 2 edges: pending set at N, SHOW at N+1.
  - One event sequence occupies 2*BLINK_HALF*BLINKS cycles, plus 1 IDLE cycle before the next grant.
- Counters never wrap: the phase counter is bounded by BLINK_HALF-1 and the blink counter by BLINKS.

Test Plan:
Use BLINK_HALF=4 and BLINKS=2 for all scenarios.
1. Reset: assert reset with events toggling.
   - Required: all outputs 0 and cur_event=0 with no clock edge; busy stays 0 after release until an event arrives.
2. Single four: ev_four pulse at edge N.
   - Required: blu=1 over edges N+1..N+4, 0 over N+5..N+8, 1 over N+9..N+12, 0 over N+13..N+16.
   - Required: IDLE at N+17, busy 1→0 at N+17, cur_event=1 throughout.
3. Simultaneous events: ev_four and ev_wicket pulse at the same edge N.
   - Required: red sequence first (cur_event=3) over N+1..N+16.
   - Required: IDLE at N+17, then blu sequence starting at edge N+18.
4. Coalescing: three ev_six pulses during a six sequence.
   - Required: exactly one further grn sequence, then IDLE.
5. Abort to rainbow: game_over rises at edge N+6 during a wicket sequence.
   - Required: RAINBOW at N+6, rainbow_en=1, red/grn/blu follow rb_* one cycle late.
   - Required: a queued ev_four is discarded.
   - Required: when game_over falls, IDLE is entered and LEDs go to 0.
6. Asynchronous reset mid-SHOW: reset asserted between edges.
   - Required: LED drops immediately.
   - Required: after release, an ev_six pulse gives the normal grn timing from scenario 2.
